// File: rtl/ex_div_seq.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional build macro DIV_ZERO_FAST_EN: zero divisor skips CALC.
module ex_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        flush_i,
  output logic [31:0] result_o,
  output logic        ready_o,
  output logic        busy_o,
  output logic [4:0]  rd_addr_o,
  output logic        rd_wen_o,
  output logic        hold_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_CALC,
    S_END
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  rd_q, rd_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;

  logic        accept;
  logic        sgn;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] q_fin;
  logic [31:0] r_fin;
  logic [31:0] res;

  // op_q[1]: remainder select, op_q[0]: unsigned
  assign accept = rst & start_i & op_i[2] & ~flush_i;
  assign sgn    = ~op_q[0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    shifted = {rem_q, quot_q[31]};
    diff    = {1'b0, shifted} - {2'b00, b_q};
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          op_d    = op_i[1:0];
          a_d     = dividend_i;
          b_d     = divisor_i;
          rd_d    = rd_addr_i;
        end
      end
      S_START: begin
        quot_d  = (sgn & a_q[31]) ? -a_q : a_q;
        b_d     = (sgn & b_q[31]) ? -b_q : b_q;
        rem_d   = '0;
        cnt_d   = '0;
        qneg_d  = sgn & (a_q[31] ^ b_q[31]);
        rneg_d  = sgn & a_q[31];
        state_d = S_CALC;
`ifdef DIV_ZERO_FAST_EN
        if (b_q == '0) state_d = S_END;
`endif
      end
      S_CALC: begin
        quot_d = {quot_q[30:0], ~diff[33]};
        rem_d  = diff[33] ? shifted[31:0] : diff[31:0];
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_END;
      end
      S_END: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      rd_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  // zero divisor bypasses sign fixup: all-ones quotient, raw dividend
  always_comb begin
    q_fin = qneg_q ? -quot_q : quot_q;
    r_fin = rneg_q ? -rem_q : rem_q;
    if (b_q == '0) begin
      q_fin = '1;
      r_fin = a_q;
    end
    res = op_q[1] ? r_fin : q_fin;
  end

  assign ready_o   = (state_q == S_END) & ~flush_i;
  assign rd_wen_o  = ready_o;
  assign result_o  = ready_o ? res : '0;
  assign rd_addr_o = ready_o ? rd_q : '0;
  assign busy_o    = state_q != S_IDLE;
  assign hold_o    = ((state_q == S_IDLE) & accept)
                   | (state_q == S_START)
                   | (state_q == S_CALC);

endmodule

// File: doc/ex_div_seq.md
EX_DIV_SEQ -- requirements
Module: ex_div_seq

Interface
- REQ-001: Parameters: none; operand and result width fixed at 32 bits.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- REQ-004: start_i  input  1  request from ex stage; sampled only in IDLE.
- REQ-005: op_i  input  3  funct3 of M-extension op: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- REQ-006: dividend_i  input  32  rs1 value (op1).
- REQ-007: divisor_i  input  32  rs2 value (op2).
- REQ-008: rd_addr_i  input  5  destination register of the request.
- REQ-009: flush_i  input  1  pipeline flush; aborts any operation.
- REQ-010: result_o  output  32  quotient or remainder; valid only while ready_o=1, else 0.
- REQ-011: ready_o  output  1  one-cycle completion pulse.
- REQ-012: busy_o  output  1  high whenever state != IDLE.
- REQ-013: rd_addr_o  output  5  captured rd; driven with result, else 0.
- REQ-014: rd_wen_o  output  1  register write enable; equals ready_o.
- REQ-015: hold_o  output  1  pipeline stall request to the control unit.

Function
- REQ-016: FSM states IDLE, START, CALC, END; IDLE->START when start_i=1 and flush_i=0; opcode, operands and rd latched on that edge.
- REQ-017: START: computes operand magnitudes (signed ops only), quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign); goes to CALC with iteration counter = 0.
- REQ-018: CALC: one radix-2 restoring step per cycle (shift, trial subtract, set quotient bit); exactly 32 cycles; counter 5 bits, goes to END when counter = 31.
- REQ-019: END: applies sign correction, drives result_o, ready_o=1, rd_wen_o=1, rd_addr_o for exactly one cycle, then returns to IDLE.
- REQ-020: Latency without fast path: ready_o high in the 34th cycle after the accepting edge (START 1 + CALC 32 + END 1).
- REQ-021: DIV/REM: the quotient is negated when the signs differ; the remainder takes the sign of the dividend; DIVU/REMU: no sign handling.
- REQ-022: Divisor = 0: quotient = 0xFFFFFFFF for both DIV and DIVU, remainder = dividend unchanged, regardless of sign.
- REQ-023: Overflow DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- REQ-024: hold_o = (IDLE and start_i and not flush_i) or state in {START, CALC}; deasserted in END.
- REQ-025: start_i while not IDLE is ignored; no queueing.
- REQ-026: flush_i=1 in any state: next state IDLE, no ready_o pulse, latched data discarded; flush_i and start_i together in IDLE: flush wins.
- REQ-027: Unsupported op_i values (0xx) are ignored in IDLE; no state change.

Reset
- REQ-028: rst=0 forces IDLE immediately; result_o=0, ready_o=0, rd_wen_o=0, rd_addr_o=0, busy_o=0, hold_o=0, counter=0, regardless of operation in progress.
- REQ-029: The first start_i is accepted on the first rising edge after rst deasserts.

Configuration
- REQ-030: Macro DIV_ZERO_FAST_EN: when defined, START with divisor = 0 goes directly to END; ready_o is then high in the 2nd cycle after the accepting edge.
- REQ-031: Without DIV_ZERO_FAST_EN, a zero divisor takes the full 34-cycle path; result values per REQ-022 are identical in both builds.

Verification
- REQ-032: DIVU 100/7, rd=5 -> after 34 cycles, a single ready_o pulse with result_o=14, rd_addr_o=5; REMU -> 2.
- REQ-033: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; busy_o and hold_o high for cycles 1..33.
- REQ-034: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
- REQ-035: DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5; latency 2 with DIV_ZERO_FAST_EN, 34 without.
- REQ-036: flush_i at CALC cycle 10 -> no ready_o, IDLE next cycle; a following DIVU 9/3 returns 3 in 34 cycles.
- REQ-037: rst=0 at CALC cycle 20 -> all outputs 0 immediately, no ready_o after release; start_i held during busy is ignored.
